// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver that samples mid-bit at a fixed baud divisor and buffers
// received bytes in a first-word-fall-through FIFO behind a valid/ready port.
module uart_rx_fifo #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_err,
    output logic             overflow,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int BCNT_W = $clog2(BAUD_DIV);
    localparam int AW     = CNT_W - 1;
    localparam logic [BCNT_W-1:0] HALF_LOAD = BCNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [BCNT_W-1:0] FULL_LOAD = BCNT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    logic              rx_meta, rx_s;
    state_t            state, state_next;
    logic [BCNT_W-1:0] bcnt, bcnt_next;
    logic [2:0]        bidx, bidx_next;
    logic [7:0]        shreg, shreg_next;
    logic              push, frame_err_next;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [CNT_W-1:0]  wr_ptr, rd_ptr;
    logic              full, pop, wr_en;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcnt      <= '0;
            bidx      <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            bcnt      <= bcnt_next;
            bidx      <= bidx_next;
            shreg     <= shreg_next;
            frame_err <= frame_err_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        bcnt_next      = bcnt;
        bidx_next      = bidx;
        shreg_next     = shreg;
        push           = 1'b0;
        frame_err_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    bcnt_next  = HALF_LOAD;
                end
            end
            START: begin
                if (bcnt != '0) begin
                    bcnt_next = bcnt - 1'b1;
                end else if (rx_s) begin
                    state_next = IDLE;
                end else begin
                    state_next = DATA;
                    bcnt_next  = FULL_LOAD;
                    bidx_next  = '0;
                end
            end
            DATA: begin
                if (bcnt != '0) begin
                    bcnt_next = bcnt - 1'b1;
                end else begin
                    shreg_next[bidx] = rx_s;
                    bcnt_next        = FULL_LOAD;
                    bidx_next        = bidx + 3'd1;
                    if (bidx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (bcnt != '0) begin
                    bcnt_next = bcnt - 1'b1;
                end else if (rx_s) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end else begin
                    frame_err_next = 1'b1;
                    state_next     = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // A held-low line stays here so a break reports one error only.
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    assign rx_valid   = (wr_ptr != rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = rx_valid && rx_ready;
    assign wr_en      = push && (!full || pop);
    assign fifo_count = wr_ptr - rd_ptr;
    assign rx_data    = rx_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            overflow <= push && full && !pop;
        end
    end

    // NOTE: the storage array has no reset; contents are only observable
    // through rx_data, which is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial stimulus with a byte scoreboard
// drained by a negedge monitor, plus flag and count checks.
module tb_uart_rx_fifo;

    // Bit period is shortened to keep the run compact; timing scales with it.
    localparam int BAUD  = 216;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
    localparam int LAT   = 3 + BAUD / 2 + 9 * BAUD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_err;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    uart_rx_fifo #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #10 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         beats = 0;
    int         beat_cyc = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         max_cnt = 0;
    logic       fe_prev = 1'b0;
    logic       ov_prev = 1'b0;
    logic [7:0] sb[$];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted beat, tracks flag pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) begin
                beats++;
                beat_cyc = cyc;
                check("beat_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("rx_data", 32'(rx_data), 32'(sb.pop_front()));
            end
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (fe_prev) check("frame_err_width", 32'(frame_err), 32'd0);
            if (ov_prev) check("overflow_width", 32'(overflow), 32'd0);
            if (frame_err && !fe_prev) fe_cnt++;
            if (overflow && !ov_prev) ov_cnt++;
        end
        fe_prev = frame_err;
        ov_prev = overflow;
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BAUD) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic send_good(input logic [7:0] b);
        sb.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 4 * BAUD; i++) begin
            if (sb.size() == 0 && !rx_valid) break;
            @(posedge clk);
            #1;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_rx_data"}, 32'(rx_data), 32'h00);
        check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int t0;
        int b0;
        int lat;
        logic [7:0] partial;

        rx       = 1'b1;
        rx_ready = 1'b1;
        rst_n    = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (BAUD) @(posedge clk);
        #1;

        // Single byte with latency measured from the start edge.
        t0 = cyc;
        b0 = beats;
        send_good(8'h41);
        wait_drain("single_drain");
        lat = beat_cyc - t0;
        check("single_beats", 32'(beats - b0), 32'd1);
        check("single_latency_window", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);
        check("single_flags", 32'(fe_cnt + ov_cnt), 32'd0);

        // Back-to-back string burst.
        max_cnt = 0;
        b0 = beats;
        send_good(8'h41);
        send_good(8'h48);
        send_good(8'h65);
        send_good(8'h6C);
        send_good(8'h6C);
        send_good(8'h6F);
        wait_drain("burst_drain");
        check("burst_beats", 32'(beats - b0), 32'd6);
        check("burst_max_count_le1", 32'(max_cnt <= 1), 32'd1);
        check("burst_flags", 32'(fe_cnt + ov_cnt), 32'd0);

        // Glitch shorter than half a bit.
        b0 = beats;
        rx = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3 * BAUD) @(posedge clk);
        #1;
        check("glitch_beats", 32'(beats - b0), 32'd0);
        check("glitch_rx_valid", 32'(rx_valid), 32'd0);
        check("glitch_frame_err", 32'(fe_cnt), 32'd0);

        // Framing error followed by a break, then a clean byte.
        b0 = beats;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (3 * BAUD) @(posedge clk);
        #1;
        drive_bit(1'b1);
        send_good(8'h3C);
        wait_drain("fe_drain");
        check("fe_pulses", 32'(fe_cnt), 32'd1);
        check("fe_beats", 32'(beats - b0), 32'd1);

        // Overflow: 17 bytes with the consumer stalled.
        rx_ready = 1'b0;
        b0 = beats;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        @(negedge clk);
        check("ovf_fifo_count", 32'(fifo_count), 32'd16);
        check("ovf_pulses", 32'(ov_cnt), 32'd1);
        check("ovf_head", 32'(rx_data), 32'h00);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_beats", 32'(beats - b0), 32'd16);
        check("ovf_count_after", 32'(fifo_count), 32'd0);

        // Reset during data bit 4 with one byte already stored.
        rx_ready = 1'b0;
        send_good(8'h77);
        @(negedge clk);
        check("rst_pre_count", 32'(fifo_count), 32'd1);
        @(posedge clk);
        #1;
        partial = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        rx = partial[4];
        repeat (BAUD / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx = 1'b1;
        sb.delete();
        check_reset_values("midbyte_reset");
        repeat (3 * BAUD) @(posedge clk);
        #1;
        check("rst_no_partial", 32'(rx_valid), 32'd0);
        rx_ready = 1'b1;
        b0 = beats;
        send_good(8'hA5);
        wait_drain("rst_drain");
        check("rst_beats", 32'(beats - b0), 32'd1);
        check("final_flags", 32'(fe_cnt * 16 + ov_cnt), 32'd17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receiver with an output FIFO, 8N1 framing at a fixed baud divisor. It converts the serial stream on `rx` into bytes and buffers them behind a valid/ready interface, so consumers such as the string/loopback logic can drain them at their own rate. It is the receiving end of the same 8N1 link the string-loopback path drives: 50 MHz clock, `BAUD_DIV` = 434 clocks per bit.

## Interface
- `BAUD_DIV`, default 434: clocks per bit period (50 MHz / 115200).
- `FIFO_DEPTH`, default 16: byte entries. Must be a power of 2.
- `CNT_W`, default 5: width of `fifo_count`. Must equal log2(`FIFO_DEPTH`) + 1.

Ports:
- `clk`  in  1: system clock. Reset is synchronous and active-low.
- `rst_n`  in  1: synchronous active-low reset. It is sampled on the rising edge of `clk`.
- `rx`  in  1: asynchronous serial input. Idle level is high.
- `rx_data`  out  8: head-of-FIFO byte. Valid only while `rx_valid` = 1.
- `rx_valid`  out  1: FIFO not empty.
- `rx_ready`  in  1: consumer accepts the head byte. A pop happens on a cycle where `rx_valid` and `rx_ready` are both 1.
- `frame_err`  out  1: one-cycle pulse when a stop bit is sampled low.
- `overflow`  out  1: one-cycle pulse when a received byte is dropped because the FIFO is full.
- `fifo_count`  out  `CNT_W`: number of bytes currently stored.

## Operation
- **Input synchronizer:** `rx` passes through 2 flops to give `rx_s`. Both flops reset to 1.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE. A baud counter `bcnt` and a bit index `bidx` (0–7) support it.
- **IDLE:** on `rx_s` = 0, go to START and load `bcnt` = `BAUD_DIV`/2 − 1.
- **START:** when `bcnt` reaches 0, resample `rx_s`.
  - If 1, treat it as a glitch and return to IDLE. No flags.
  - If 0, go to DATA with `bcnt` = `BAUD_DIV` − 1 and `bidx` = 0.
- **DATA:** each time `bcnt` reaches 0, shift `rx_s` into `shreg[bidx]` (LSB first) and reload `bcnt`. After `bidx` = 7, go to STOP.
- **STOP:** when `bcnt` reaches 0, sample `rx_s`.
  - If 1, push `shreg` into the FIFO and return to IDLE.
  - If 0, pulse `frame_err`, discard the byte and go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s` = 1, then go to IDLE. A held-low line (break) therefore produces exactly one `frame_err`.
- **FIFO:** first-word-fall-through. `rx_data` is driven from the head entry. Read and write pointers are `CNT_W` bits wide and wrap modulo 2·`FIFO_DEPTH`.
- **Push with FIFO full and no pop in the same cycle:** the byte is dropped, `overflow` pulses, and stored contents are unchanged.
- **Push and pop in the same cycle while full:** both are performed and `fifo_count` stays at `FIFO_DEPTH`. No overflow.
- **Push while empty:** no bypass. The byte appears on `rx_data` with `rx_valid` = 1 in the cycle after the push.
- **Pop while empty:** ignored.

## Timing
- **Reset values:** `rx_valid`=0, `rx_data`=8'h00, `frame_err`=0, `overflow`=0, `fifo_count`=0. The FSM is in IDLE and the pointers are 0.
- **Reset mid-byte:** a partial byte is discarded and nothing is pushed.
- **Sampling point:** middle of each bit. It lands 217 + k·434 clocks after start detection, where k = 1..8 for data bits and k = 9 for the stop bit.
- **Latency:** from the falling edge of `rx` to `rx_valid` rising, with the FIFO empty: 2 synchronizer cycles + 217 + 9·434 + 1 push cycle = 4126 clocks ±1. This is about 9.5 bit periods.
- **Back-to-back bytes:** the FSM is back in IDLE half a bit before the stop bit ends, so a start bit immediately following a stop bit is detected. Sustained full-rate input is lossless while `rx_ready` = 1.
- **`fifo_count` timing:** updates on the clock edge after the push or pop.
- **Pulse width:** `frame_err` and `overflow` are high for exactly one clock.

## Test plan
- **Single byte:** send 0x41 (bit period 8680 ns), `rx_ready`=1. Required: one `rx_valid` beat with `rx_data`=0x41, about 4126 clocks after the start edge. No flags.
- **String burst:** send 0x41,0x48,0x65,0x6C,0x6C,0x6F back-to-back with `rx_ready`=1. Required: six beats in that order, `fifo_count` never above 1, no flags.
- **Glitch:** drive `rx` low for 100 clocks, then high. Required: no `rx_valid`, no `frame_err`, FSM returns to IDLE.
- **Framing error:** send 0x55 with the stop bit driven 0, then hold `rx` low for 3 bit periods, then send 0x3C normally. Required: exactly one `frame_err` pulse, 0x55 not delivered, 0x3C delivered.
- **Overflow:** with `rx_ready`=0, send 17 bytes 0x00..0x10. Required: `fifo_count`=16, one `overflow` pulse on the 17th byte. Then raise `rx_ready`: bytes 0x00..0x0F are delivered in order and 0x10 is absent.
- **Reset mid-byte:** pulse `rst_n` low for 1 clock during data bit 4, then send 0xA5. Required: outputs at reset values, no partial byte, 0xA5 received correctly.
